param_readout: RTL

PARAM_READOUT -- requirements
Module: param_readout

---
 rtl/param_readout.sv | 123 ++++++++++++
 1 files changed

// File: rtl/param_readout.sv
// Streams a fixed parameter record over a valid/ready byte interface.
// Optional trailing XOR checksum byte is enabled with `define PARAM_READOUT_CHECKSUM_EN.
module param_readout #(
  parameter bit          A = 1'b1,
  parameter int          B = 5,
  parameter int unsigned C = 5,
  parameter bit [31:0]   D = 32'd5
) (
  input  logic       i_clk,
  input  logic       i_arstn,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_last
);

  localparam int unsigned IDX_W = 4;
`ifdef PARAM_READOUT_CHECKSUM_EN
  localparam int unsigned NUM_BYTES = 15;
`else
  localparam int unsigned NUM_BYTES = 14;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  localparam logic [31:0] B_W = 32'(B);
  localparam logic [31:0] C_W = 32'(C);
  localparam logic [31:0] D_W = D;
  localparam logic [7:0]  MAGIC = 8'hA5;

`ifdef PARAM_READOUT_CHECKSUM_EN
  // XOR of every preceding record byte, folded at elaboration time
  localparam logic [7:0] CSUM = MAGIC ^ {7'b0, A}
                              ^ B_W[7:0] ^ B_W[15:8] ^ B_W[23:16] ^ B_W[31:24]
                              ^ C_W[7:0] ^ C_W[15:8] ^ C_W[23:16] ^ C_W[31:24]
                              ^ D_W[7:0] ^ D_W[15:8] ^ D_W[23:16] ^ D_W[31:24];
`endif

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;

  assign idx_nxt = idx + IDX_W'(1);

  // Record byte lookup; 32-bit fields are little-endian
  function automatic logic [7:0] rec_byte(input logic [IDX_W-1:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = MAGIC;
      4'd1:    b = {7'b0, A};
      4'd2:    b = B_W[7:0];
      4'd3:    b = B_W[15:8];
      4'd4:    b = B_W[23:16];
      4'd5:    b = B_W[31:24];
      4'd6:    b = C_W[7:0];
      4'd7:    b = C_W[15:8];
      4'd8:    b = C_W[23:16];
      4'd9:    b = C_W[31:24];
      4'd10:   b = D_W[7:0];
      4'd11:   b = D_W[15:8];
      4'd12:   b = D_W[23:16];
      4'd13:   b = D_W[31:24];
`ifdef PARAM_READOUT_CHECKSUM_EN
      4'd14:   b = CSUM;
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // While in SEND, o_valid is always high, so a transfer is simply i_ready
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state   <= IDLE;
      idx     <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= SEND;
            idx     <= '0;
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
            o_last  <= 1'b0;
            o_data  <= rec_byte('0);
          end
        end
        SEND: begin
          if (i_ready) begin
            if (idx == LAST_IDX) begin
              state   <= IDLE;
              idx     <= '0;
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_last  <= 1'b0;
              o_data  <= 8'h00;
            end else begin
              idx    <= idx_nxt;
              o_data <= rec_byte(idx_nxt);
              o_last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: begin
          state   <= IDLE;
          idx     <= '0;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_last  <= 1'b0;
          o_data  <= 8'h00;
        end
      endcase
    end
  end

endmodule
